// File: rtl/oh_parity_acc.sv
`default_nettype none
// ============================================================================
// Module   : oh_parity_acc (with leaf cell xor4)
// Brief    : Streaming packet-parity accumulator over a valid/ready beat
//            stream, built on a 4-input XOR reduction tree.
// Revision : 1.0  initial release
// ============================================================================

module xor4 #(
    parameter PROP = "DEFAULT"
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic z
);
    generate
        if (PROP == "") begin : g_prop_check
            $error("xor4: PROP must not be empty");
        end
    endgenerate

    assign z = a ^ b ^ c ^ d;
endmodule

module oh_parity_acc #(
    parameter int DW   = 32,
    parameter int CW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_parity,
    output logic [CW-1:0] out_beats,
    output logic          out_sat
);
    generate
        if (((DW % 4) != 0) || (DW < 4)) begin : g_dw_check
            $error("oh_parity_acc: DW must be a non-zero multiple of 4");
        end
    endgenerate

    // Node count at each tree level: level 0 is the raw beat, each level
    // above folds groups of four.
    function automatic int f_nodes(input int lvl);
        int n;
        n = DW;
        for (int j = 0; j < lvl; j++) n = (n + 3) / 4;
        return n;
    endfunction

    function automatic int f_levels();
        int n;
        int l;
        n = DW;
        l = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            l++;
        end
        return l;
    endfunction

    localparam int            c_levels  = f_levels();
    localparam logic [CW-1:0] c_cnt_max = '1;

    generate
        for (genvar l = 1; l <= c_levels; l++) begin : g_lvl
            localparam int c_n_prev = f_nodes(l - 1);
            localparam int c_n      = f_nodes(l);

            logic [c_n_prev-1:0] w_prev;
            logic [4*c_n-1:0]    w_lin;
            logic [c_n-1:0]      w_out;

            if (l == 1) begin : g_src_in
                assign w_prev = in_data;
            end else begin : g_src_lvl
                assign w_prev = g_lvl[l-1].w_out;
            end

            if (4 * c_n == c_n_prev) begin : g_nopad
                assign w_lin = w_prev;
            end else begin : g_pad
                assign w_lin = {{(4*c_n - c_n_prev){1'b0}}, w_prev};
            end

            for (genvar i = 0; i < c_n; i++) begin : g_cell
                xor4 #(.PROP(PROP)) u_xor4 (
                    .a (w_lin[4*i+0]),
                    .b (w_lin[4*i+1]),
                    .c (w_lin[4*i+2]),
                    .d (w_lin[4*i+3]),
                    .z (w_out[i])
                );
            end
        end
    endgenerate

    logic          w_beat_par;
    logic          w_accept;
    logic          w_s1_adv;
    logic          w_cnt_ovf;
    logic [CW-1:0] w_cnt_inc;

    logic          r_v1;
    logic          r_p1;
    logic          r_last1;
    logic          r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_sat;

    assign w_beat_par = g_lvl[c_levels].w_out[0];

    // Only a last beat can be held in S1; non-last beats fold into the
    // accumulator unconditionally.
    assign w_s1_adv  = r_v1 & (~r_last1 | ~out_valid | out_ready);
    assign in_ready  = ~reset & (~r_v1 | w_s1_adv);
    assign w_accept  = in_valid & in_ready;

    assign w_cnt_ovf = (r_cnt == c_cnt_max);
    assign w_cnt_inc = w_cnt_ovf ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_p1       <= 1'b0;
            r_last1    <= 1'b0;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_beats  <= '0;
            out_sat    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_v1    <= 1'b1;
                r_p1    <= w_beat_par;
                r_last1 <= in_last;
            end else if (w_s1_adv) begin
                r_v1    <= 1'b0;
            end

            if (w_s1_adv && !r_last1) begin
                r_acc <= r_acc ^ r_p1;
                r_cnt <= w_cnt_inc;
                r_sat <= r_sat | w_cnt_ovf;
            end else if (w_s1_adv && r_last1) begin
                r_acc <= 1'b0;
                r_cnt <= '0;
                r_sat <= 1'b0;
            end

            // A new result loading on the consume edge takes priority.
            if (w_s1_adv && r_last1) begin
                out_valid  <= 1'b1;
                out_parity <= r_acc ^ r_p1;
                out_beats  <= w_cnt_inc;
                out_sat    <= r_sat | w_cnt_ovf;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_oh_parity_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_oh_parity_acc
// Brief    : Scoreboard bench for oh_parity_acc; a CW=8 and a CW=2 instance
//            share one stimulus stream, each with its own monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_oh_parity_acc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid;
    logic        in_last;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_parity, a_out_sat;
    logic [7:0]  a_out_beats;
    logic        b_in_ready, b_out_valid, b_out_parity, b_out_sat;
    logic [1:0]  b_out_beats;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic parity;
        int   n;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    oh_parity_acc #(.DW(32), .CW(8), .PROP("DEFAULT")) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_parity (a_out_parity),
        .out_beats  (a_out_beats),
        .out_sat    (a_out_sat)
    );

    oh_parity_acc #(.DW(32), .CW(2), .PROP("DEFAULT")) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_parity (b_out_parity),
        .out_beats  (b_out_beats),
        .out_sat    (b_out_sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat_beats(input int n, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic int sat_flag(input int n, input int cw);
        return (n > ((1 << cw) - 1)) ? 1 : 0;
    endfunction

    task automatic push_exp(input logic p, input int n);
        exp_t e;
        e.parity = p;
        e.n      = n;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'bx;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [31:0] d, input logic l, output logic rdy_first);
        logic rdy;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        rdy_first = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            rdy = a_in_ready;
            if (c == 0) rdy_first = rdy;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got no in_ready expected in_ready=1 within 200 cycles");
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && a_out_valid && out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got result parity=%0d beats=%0d expected none",
                         a_out_parity, a_out_beats);
            end else begin
                e = qa.pop_front();
                check("a_parity", 32'(a_out_parity), 32'(e.parity));
                check("a_beats",  32'(a_out_beats),  32'(sat_beats(e.n, 8)));
                check("a_sat",    32'(a_out_sat),    32'(sat_flag(e.n, 8)));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && b_out_valid && out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got result parity=%0d beats=%0d expected none",
                         b_out_parity, b_out_beats);
            end else begin
                e = qb.pop_front();
                check("b_parity", 32'(b_out_parity), 32'(e.parity));
                check("b_beats",  32'(b_out_beats),  32'(sat_beats(e.n, 2)));
                check("b_sat",    32'(b_out_sat),    32'(sat_flag(e.n, 2)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       r;
        logic [9:0] par3;
        par3 = 10'b0110010110;

        idle();
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   32'(a_in_ready),   0);
        check("rst_out_valid",  32'(a_out_valid),  0);
        check("rst_out_parity", 32'(a_out_parity), 0);
        check("rst_out_beats",  32'(a_out_beats),  0);
        check("rst_out_sat",    32'(a_out_sat),    0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(a_in_ready), 1);
        @(posedge clk);
        #1;

        // Single beat: latency two edges from presentation
        out_ready = 1'b1;
        push_exp(1'b1, 1);
        send_beat(32'h0000_0001, 1'b1, r);
        idle();
        @(negedge clk);
        check("t1_lat_lo", 32'(a_out_valid), 0);
        @(negedge clk);
        check("t1_lat_hi", 32'(a_out_valid), 1);
        @(posedge clk);
        #1;

        // Three-beat packet
        push_exp(1'b1, 3);
        send_beat(32'hFFFF_FFFF, 1'b0, r);
        send_beat(32'h0000_0003, 1'b0, r);
        send_beat(32'h8000_0000, 1'b1, r);

        // Ten back-to-back single-beat packets
        for (int i = 0; i < 10; i++) begin
            push_exp(par3[i], 1);
            send_beat(32'(i), 1'b1, r);
            check("t3_ready", 32'(r), 1);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("t3_drained_a", 32'(qa.size()), 0);
        check("t3_drained_b", 32'(qb.size()), 0);

        // Backpressure: pending result, then a two-beat packet
        out_ready = 1'b0;
        push_exp(1'b1, 1);
        send_beat(32'h0000_0001, 1'b1, r);
        idle();
        repeat (2) @(posedge clk);
        #1;
        push_exp(1'b0, 2);
        send_beat(32'h0000_0003, 1'b0, r);
        check("t4_rdy_beat0", 32'(r), 1);
        send_beat(32'h0000_0000, 1'b1, r);
        check("t4_rdy_beat1", 32'(r), 1);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_ready", 32'(a_in_ready),   0);
            check("t4_hold_valid",  32'(a_out_valid),  1);
            check("t4_hold_parity", 32'(a_out_parity), 1);
            check("t4_hold_beats",  32'(a_out_beats),  1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_drained", 32'(qa.size()), 0);

        // Six beats of 0x1: saturates the CW=2 counter
        push_exp(1'b0, 6);
        for (int i = 0; i < 6; i++) send_beat(32'h0000_0001, (i == 5), r);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset with a pending result and a partial packet in flight
        out_ready = 1'b0;
        send_beat(32'h0000_0001, 1'b1, r);
        send_beat(32'h0000_0001, 1'b0, r);
        send_beat(32'h0000_0000, 1'b0, r);
        idle();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_rst_valid",  32'(a_out_valid),  0);
        check("t6_rst_parity", 32'(a_out_parity), 0);
        check("t6_rst_beats",  32'(a_out_beats),  0);
        check("t6_rst_sat",    32'(a_out_sat),    0);
        check("t6_rst_ready",  32'(a_in_ready),   0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        push_exp(1'b1, 1);
        send_beat(32'h0000_0007, 1'b1, r);
        idle();

        for (int c = 0; c < 100 && (qa.size() != 0 || qb.size() != 0); c++) @(posedge clk);
        #1;
        check("final_drained_a", 32'(qa.size()), 0);
        check("final_drained_b", 32'(qb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
